// File: rtl/btn_conditioner_if.sv
// rtl/btn_conditioner_if.sv - button pin in, conditioned level/pulses/count out
interface btn_conditioner_if #(
    parameter int CNT_W = 8
);
    logic             USER_BTN;
    logic             btn_level;
    logic             press_pulse;
    logic             release_pulse;
    logic             long_pulse;
    logic             repeat_pulse;
    logic [CNT_W-1:0] press_count;

    modport master (
        input  USER_BTN,
        output btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, press_count
    );

    modport slave (
        output USER_BTN,
        input  btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, press_count
    );
endinterface

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - push-button sync, debounce, press/release/long pulses, press counter
// Optional auto-repeat pulse is built only when BTN_AUTOREPEAT_EN is defined.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LONG_CYCLES     = 12000000,
    parameter int REPEAT_CYCLES   = 2400000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1,
    parameter int CNT_W           = 8
) (
    input  logic                   CLK12M,
    input  logic                   RST_BTN,
    btn_conditioner_if.master      btn
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 1) begin : g_bad_params
            $error("btn_conditioner: illegal parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_t;

    logic             pressed;
    logic             sync1;
    logic             s;
    state_t           state;
    logic [DB_W-1:0]  db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             long_q;
    logic [CNT_W-1:0] count_q;

    assign pressed = btn.USER_BTN ^ BTN_ACTIVE_LOW;

    always_ff @(posedge CLK12M or posedge RST_BTN) begin
        if (RST_BTN) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= pressed;
            s     <= sync1;
        end
    end

    // Debounce counter counts consecutive matching samples; hold counter saturates so long fires once.
    always_ff @(posedge CLK12M or posedge RST_BTN) begin
        if (RST_BTN) begin
            state     <= IDLE;
            db_cnt    <= '0;
            hold_cnt  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            case (state)
                IDLE: begin
                    level_q  <= 1'b0;
                    hold_cnt <= '0;
                    if (s) begin
                        state  <= DB_PRESS;
                        db_cnt <= DB_W'(1);
                    end else begin
                        db_cnt <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!s) begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end else if (db_cnt >= DB_MAX) begin
                        state    <= HELD;
                        db_cnt   <= '0;
                        hold_cnt <= '0;
                        level_q  <= 1'b1;
                        press_q  <= 1'b1;
                        count_q  <= count_q + 1'b1;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (hold_cnt < HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 1'b1;
                        if (hold_cnt == HOLD_LAST) begin
                            long_q <= 1'b1;
                        end
                    end
                    if (!s) begin
                        state  <= DB_RELEASE;
                        db_cnt <= DB_W'(1);
                    end
                end
                DB_RELEASE: begin
                    if (s) begin
                        state  <= HELD;
                        db_cnt <= '0;
                    end else if (db_cnt >= DB_MAX) begin
                        state     <= IDLE;
                        db_cnt    <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt;
    logic             repeat_q;

    // Repeats only run once the hold counter has saturated, i.e. after long_pulse.
    always_ff @(posedge CLK12M or posedge RST_BTN) begin
        if (RST_BTN) begin
            rep_cnt  <= '0;
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= 1'b0;
            if (state == IDLE) begin
                rep_cnt <= '0;
            end else if (state == HELD && hold_cnt == HOLD_MAX) begin
                if (rep_cnt == REP_LAST) begin
                    rep_cnt  <= '0;
                    repeat_q <= 1'b1;
                end else begin
                    rep_cnt <= rep_cnt + 1'b1;
                end
            end
        end
    end

    assign btn.repeat_pulse = repeat_q;
`else
    assign btn.repeat_pulse = 1'b0;
`endif

    assign btn.btn_level     = level_q;
    assign btn.press_pulse   = press_q;
    assign btn.release_pulse = release_q;
    assign btn.long_pulse    = long_q;
    assign btn.press_count   = count_q;
endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - self-checking bench for btn_conditioner
module tb_btn_conditioner;
    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 5;
    localparam int W = 8;

    typedef struct {
        int unsigned width;
        int          accept;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    btn_conditioner_if #(.CNT_W(W)) bif ();

    btn_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES(L),
        .REPEAT_CYCLES(R),
        .BTN_ACTIVE_LOW(1'b1),
        .CNT_W(W)
    ) dut (
        .CLK12M(clk),
        .RST_BTN(rst),
        .btn(bif)
    );

    // Reference model: level follows any run of D+1 identical observed samples;
    // HELD means "level is 1 and the last observed sample was pressed".
    bit hist[$];
    bit m_prev_s, m_run_val, m_level, m_press, m_release, m_long, m_repeat;
    int m_run_len, m_held, m_count;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        hist = '{1'b0, 1'b0};
        m_prev_s = 0; m_run_val = 0; m_run_len = 0; m_held = 0;
        m_level = 0; m_press = 0; m_release = 0; m_long = 0; m_repeat = 0;
        m_count = 0;
    endtask

    task automatic model_edge(input bit p);
        bit s;
        hist.push_back(p);
        s = hist[0];
        void'(hist.pop_front());
        m_press = 0; m_release = 0; m_long = 0; m_repeat = 0;
        if (m_level && m_prev_s) begin
            m_held++;
            if (m_held == L) m_long = 1;
`ifdef BTN_AUTOREPEAT_EN
            else if (m_held > L && (m_held - L) % R == 0) m_repeat = 1;
`endif
        end
        if (s == m_run_val) m_run_len++;
        else begin
            m_run_val = s;
            m_run_len = 1;
        end
        if (s != m_level && m_run_len == D + 1) begin
            m_level = s;
            m_held  = 0;
            if (s) begin
                m_press = 1;
                m_count = (m_count + 1) % (1 << W);
            end else begin
                m_release = 1;
            end
        end
        m_prev_s = s;
    endtask

    task automatic compare_all();
        check("btn_level",     bif.btn_level,     m_level);
        check("press_pulse",   bif.press_pulse,   m_press);
        check("release_pulse", bif.release_pulse, m_release);
        check("long_pulse",    bif.long_pulse,    m_long);
        check("repeat_pulse",  bif.repeat_pulse,  m_repeat);
        check("press_count",   bif.press_count,   m_count);
    endtask

    task automatic step(input bit p);
        bif.USER_BTN = ~p;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(p);
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"},   bif.btn_level,     0);
        check({tag, "_press"},   bif.press_pulse,   0);
        check({tag, "_release"}, bif.release_pulse, 0);
        check({tag, "_long"},    bif.long_pulse,    0);
        check({tag, "_repeat"},  bif.repeat_pulse,  0);
        check({tag, "_count"},   bif.press_count,   0);
    endtask

    task automatic press_until_level(input string tag, input int exp_count);
        int lat;
        lat = 0;
        while (!bif.btn_level && lat < 50) begin
            step(1);
            lat++;
        end
        check({tag, "_latency"}, lat - 1, D + 2);
        check({tag, "_pulse"}, bif.press_pulse, 1);
        check({tag, "_count"}, bif.press_count, exp_count);
    endtask

    task automatic release_until_idle(input string tag);
        int lat;
        lat = 0;
        while (bif.btn_level && lat < 50) begin
            step(0);
            lat++;
        end
        check({tag, "_latency"}, lat - 1, D + 2);
        check({tag, "_pulse"}, bif.release_pulse, 1);
    endtask

    initial begin
        vec_t tbl[5];
        int   nlong, nrep, first_long, first_rep, npress, nrel, cnt255;
        bit   val;
        int   run;

        tbl[0] = '{1, 0};
        tbl[1] = '{3, 0};
        tbl[2] = '{4, 0};
        tbl[3] = '{5, 1};
        tbl[4] = '{7, 1};

        bif.USER_BTN = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (5) step(0);

        // Clean press, long hold, release
        press_until_level("clean_press", 1);
        nlong = 0; nrep = 0; first_long = -1; first_rep = -1;
        for (int m = 1; m <= 39; m++) begin
            step(1);
            if (bif.long_pulse) begin
                nlong++;
                if (first_long < 0) first_long = m;
            end
            if (bif.repeat_pulse) begin
                nrep++;
                if (first_rep < 0) first_rep = m;
            end
        end
        check("long_offset", first_long, L);
        check("long_once", nlong, 1);
`ifdef BTN_AUTOREPEAT_EN
        check("repeat_first", first_rep, L + R);
        check("repeat_count", nrep, 3);
`else
        check("repeat_count", nrep, 0);
`endif
        check("count_after_hold", bif.press_count, 1);
        release_until_idle("clean_release");
        repeat (5) step(0);

        // Bounce: 3 pressed, 2 released, then held
        npress = 0;
        repeat (3) begin step(1); npress += bif.press_pulse; end
        repeat (2) begin step(0); npress += bif.press_pulse; end
        check("bounce_no_pulse", npress, 0);
        press_until_level("bounce_press", 2);
        release_until_idle("bounce_release");
        repeat (5) step(0);

        // Glitch-width table
        for (int i = 0; i < 5; i++) begin
            npress = 0; nrel = 0;
            for (int k = 0; k < int'(tbl[i].width); k++) begin
                step(1);
                npress += bif.press_pulse;
            end
            repeat (14) begin
                step(0);
                npress += bif.press_pulse;
                nrel   += bif.release_pulse;
            end
            check($sformatf("glitch%0d_press", tbl[i].width), npress, tbl[i].accept);
            check($sformatf("glitch%0d_release", tbl[i].width), nrel, tbl[i].accept);
        end

        // Reset mid-hold
        press_until_level("pre_reset_press", m_count + 1);
        repeat (3) step(1);
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        model_reset();
        step(1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        press_until_level("post_reset_press", 1);
        release_until_idle("post_reset_release");

        // Counter wrap after fresh reset
        rst = 1'b1;
        step(0);
        rst = 1'b0;
        check("wrap_start", bif.press_count, 0);
        npress = 0; cnt255 = -1;
        for (int n = 0; n < 256; n++) begin
            repeat (8) begin step(1); npress += bif.press_pulse; end
            if (n == 254) cnt255 = bif.press_count;
            repeat (8) step(0);
        end
        check("count_at_255", cnt255, 255);
        check("wrap_press_pulses", npress, 256);
        check("wrap_count", bif.press_count, 0);

        // Random runs against the model
        val = 0;
        for (int n = 0; n < 250; n++) begin
            val = ~val;
            run = $urandom_range(1, 30);
            repeat (run) step(val);
        end
        repeat (20) step(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
Conditions the raw MAX1000 user push-button before it reaches the Nios system's button PIO input. The block synchronises the button to CLK12M, debounces both press and release, and drives a clean level for the PIO. It also produces single-cycle press, release and long-press pulses, plus a wrapping press counter, so software and fabric logic never see contact bounce.

Parameters:
DEBOUNCE_CYCLES, 120000, number of consecutive stable synchronised cycles needed to accept a press or release (10 ms at 12 MHz); legal range >= 2
LONG_CYCLES, 12000000, cycles after btn_level rises at which long_pulse fires (1 s); must be > DEBOUNCE_CYCLES
REPEAT_CYCLES, 2400000, auto-repeat period (200 ms); used only with the optional feature
BTN_ACTIVE_LOW, 1, 1 = USER_BTN reads 0 when pressed; 0 = USER_BTN reads 1 when pressed
CNT_W, 8, width of press_count

Ports:
CLK12M  in  1  system clock, 12 MHz; the only clock
RST_BTN  in  1  asynchronous reset, active-high
USER_BTN  in  1  raw asynchronous button pin
btn_level  out  1  debounced level, 1 = pressed; feeds the PIO button export
press_pulse  out  1  one-cycle pulse on an accepted press
release_pulse  out  1  one-cycle pulse on an accepted release
long_pulse  out  1  one-cycle pulse when a hold reaches LONG_CYCLES
repeat_pulse  out  1  one-cycle auto-repeat pulse (see Optional Feature)
press_count  out  CNT_W  count of accepted presses

Behaviour:
- Reset and clocking: one clock, CLK12M. RST_BTN is asynchronous and active-high. While it is asserted, all flops clear: FSM = IDLE, sync flops = unpressed, counters = 0, and every output = 0.
- Normalisation: pressed = USER_BTN XOR BTN_ACTIVE_LOW.
- Synchronisation: pressed passes through a 2-flop synchroniser to give s. s is the only signal the FSM sees.
- FSM states and transitions:
  - IDLE: btn_level = 0. s = 1 -> DB_PRESS, debounce counter starts at 1.
  - DB_PRESS: s = 0 -> IDLE, counter cleared. s = 1 -> counter increments. When DEBOUNCE_CYCLES consecutive s = 1 cycles are reached -> HELD.
  - HELD: btn_level = 1. The hold counter increments each cycle and saturates at LONG_CYCLES. s = 0 -> DB_RELEASE.
  - DB_RELEASE: btn_level stays 1 and the hold counter is frozen. s = 1 -> HELD, hold counter keeps its value. DEBOUNCE_CYCLES consecutive s = 0 cycles -> IDLE.
- Press latency: if edge N is the first CLK12M edge that samples a pressed raw level and the level stays stable, btn_level and press_pulse assert at edge N+2+DEBOUNCE_CYCLES. Release is symmetric: btn_level falls and release_pulse pulses at the same edge.
- Bounce handling: any bounce shorter than DEBOUNCE_CYCLES produces no output change and no pulse.
- long_pulse: fires exactly once per hold, LONG_CYCLES edges after btn_level rose, counted over cycles spent in HELD. It never fires from DB_RELEASE or IDLE.
- press_count: increments on press_pulse and wraps modulo 2^CNT_W (255 -> 0 at the default width).
- Pulse exclusivity: press_pulse, release_pulse and long_pulse are mutually exclusive by construction. All outputs are registered.
- Reset mid-hold: asserting RST_BTN during a hold returns the block to IDLE with btn_level = 0 and no release_pulse. After reset, a button still held must re-debounce, which produces a fresh press_pulse.

Optional Feature:
Macro BTN_AUTOREPEAT_EN.
- Defined: while the FSM is in HELD after long_pulse has fired, repeat_pulse fires every REPEAT_CYCLES HELD cycles. The first repeat comes REPEAT_CYCLES cycles after long_pulse. The repeat counter freezes in DB_RELEASE and clears on entry to IDLE. Repeats do not affect press_count.
- Not defined: repeat_pulse is tied to 0, no repeat counter is synthesised, and REPEAT_CYCLES is ignored.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5, BTN_ACTIVE_LOW=1, CNT_W=8.)
- Clean press: USER_BTN 1 -> 0 sampled at edge 10 and held -> btn_level = 1 and press_pulse high for one cycle at edge 16; press_count = 1.
- Bounce: USER_BTN low for 3 cycles, high for 2 cycles, then low and held -> no pulse during the glitch; btn_level rises 6 edges after the final low is sampled.
- Long press without macro: hold for 40 cycles after btn_level rises -> single long_pulse 20 edges after btn_level rose; repeat_pulse stays 0. Release -> release_pulse 6 edges after the release is sampled.
- Auto-repeat with BTN_AUTOREPEAT_EN: hold as above -> repeat_pulse at +25, +30, +35 after btn_level rose; press_count unchanged at 1.
- Wrap: 256 clean press/release cycles -> press_count returns to 0 and 256 press_pulses are counted.
- Reset mid-hold: assert RST_BTN in HELD with the button still low -> all outputs 0 immediately (asynchronously). After deassertion, btn_level re-asserts 6 edges later with a new press_pulse.
